// File: rtl/quant_scheduler.sv
// Shares one 8x8 quantizer between the Y/Cb/Cr DCT streams in MCU order, tracks blocks
// in flight, and buffers tagged results for the entropy stage under credit-based issue.
module quant_scheduler #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned Q_LATENCY  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                y_valid,
    input  logic                cb_valid,
    input  logic                cr_valid,
    output logic                y_ready,
    output logic                cb_ready,
    output logic                cr_ready,
    input  logic signed [10:0]  y_z      [0:7][0:7],
    input  logic signed [10:0]  cb_z     [0:7][0:7],
    input  logic signed [10:0]  cr_z     [0:7][0:7],
    output logic                q_enable,
    output logic signed [10:0]  q_z      [0:7][0:7],
    output logic                q_table_sel,
    input  logic                q_out_enable,
    input  logic signed [10:0]  q_result [0:7][0:7],
    output logic                out_valid,
    input  logic                out_ready,
    output logic [1:0]          out_chan,
    output logic signed [10:0]  out_blk  [0:7][0:7],
    output logic                mcu_done,
    output logic [15:0]         mcu_count,
    output logic                err
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {S_Y, S_CB, S_CR} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      inflight, fifo_count;
    logic [CW:0]        occupancy;
    logic               credit, hs, capture, spurious, pop;

    logic [1:0]         tag_mem  [FIFO_DEPTH];
    logic [PW-1:0]      tag_wr, tag_rd;
    logic signed [10:0] fifo_blk [FIFO_DEPTH][0:7][0:7];
    logic [1:0]         fifo_chan[FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    // Blocks already issued count against the FIFO so every result has a slot waiting.
    assign occupancy = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit    = occupancy < (CW+1)'(FIFO_DEPTH);
    assign capture   = q_out_enable && (inflight != '0);
    assign spurious  = q_out_enable && (inflight == '0);
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid && out_ready;
    assign out_blk   = fifo_blk[rd_ptr];
    assign out_chan  = fifo_chan[rd_ptr];
    assign mcu_done  = pop && (out_chan == 2'd2);

    always_comb begin
        state_d  = state_q;
        y_ready  = 1'b0;
        cb_ready = 1'b0;
        cr_ready = 1'b0;
        hs       = 1'b0;
        case (state_q)
            S_Y: begin
                y_ready = credit;
                if (y_valid && credit) begin
                    hs      = 1'b1;
                    state_d = S_CB;
                end
            end
            S_CB: begin
                cb_ready = credit;
                if (cb_valid && credit) begin
                    hs      = 1'b1;
                    state_d = S_CR;
                end
            end
            S_CR: begin
                cr_ready = credit;
                if (cr_valid && credit) begin
                    hs      = 1'b1;
                    state_d = S_Y;
                end
            end
            default: state_d = S_Y;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_Y;
            q_enable    <= 1'b0;
            q_table_sel <= 1'b0;
            q_z         <= '{default: '0};
            inflight    <= '0;
            fifo_count  <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_mem     <= '{default: '0};
            fifo_chan   <= '{default: '0};
            fifo_blk    <= '{default: '0};
            mcu_count   <= '0;
            err         <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_enable <= hs;
            if (hs) begin
                q_table_sel     <= (state_q != S_Y);
                tag_mem[tag_wr] <= state_q;
                tag_wr          <= ptr_inc(tag_wr);
                case (state_q)
                    S_Y:     q_z <= y_z;
                    S_CB:    q_z <= cb_z;
                    default: q_z <= cr_z;
                endcase
            end
            case ({hs, capture})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: ;
            endcase
            if (capture) begin
                fifo_blk[wr_ptr]  <= q_result;
                fifo_chan[wr_ptr] <= tag_mem[tag_rd];
                wr_ptr            <= ptr_inc(wr_ptr);
                tag_rd            <= ptr_inc(tag_rd);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
            if (mcu_done) mcu_count <= mcu_count + 16'd1;
            if (spurious) err <= 1'b1;
        end
    end

    a_no_full_push: assert property (@(posedge clk) disable iff (rst)
        !(capture && fifo_count == CW'(FIFO_DEPTH)));
    a_latency: assert property (@(posedge clk) disable iff (rst)
        capture |-> $past(q_enable, Q_LATENCY));

endmodule

// File: tb/tb_quant_scheduler.sv
// Scoreboard bench for quant_scheduler: identity quantizer model with 4-cycle latency,
// per-cycle ready/issue/output checks against a bench-side credit and FIFO model.
module tb_quant_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, y_valid, cb_valid, cr_valid, y_ready, cb_ready, cr_ready;
    logic signed [10:0] y_z [0:7][0:7], cb_z [0:7][0:7], cr_z [0:7][0:7];
    logic               q_enable, q_table_sel, q_out_enable;
    logic signed [10:0] q_z [0:7][0:7], q_result [0:7][0:7];
    logic               out_valid, out_ready, mcu_done, err;
    logic [1:0]         out_chan;
    logic signed [10:0] out_blk [0:7][0:7];
    logic [15:0]        mcu_count;

    quant_scheduler #(.FIFO_DEPTH(4), .Q_LATENCY(4)) dut (
        .clk(clk), .rst(rst),
        .y_valid(y_valid), .cb_valid(cb_valid), .cr_valid(cr_valid),
        .y_ready(y_ready), .cb_ready(cb_ready), .cr_ready(cr_ready),
        .y_z(y_z), .cb_z(cb_z), .cr_z(cr_z),
        .q_enable(q_enable), .q_z(q_z), .q_table_sel(q_table_sel),
        .q_out_enable(q_out_enable), .q_result(q_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_blk(out_blk), .mcu_done(mcu_done), .mcu_count(mcu_count), .err(err)
    );

    // Quantizer model: identity result, fixed 4-cycle latency, plus a spurious-pulse hook.
    logic [3:0]         pipe_v;
    logic signed [10:0] pipe_b [4][0:7][0:7];
    logic               spur;
    always @(posedge clk) begin
        if (rst) pipe_v <= '0;
        else     pipe_v <= {pipe_v[2:0], q_enable};
        pipe_b[0] <= q_z;
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
        pipe_b[3] <= pipe_b[2];
    end
    assign q_out_enable = pipe_v[3] | spur;
    assign q_result     = pipe_b[3];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] blk_hash(input logic signed [10:0] b [0:7][0:7]);
        logic [31:0] h = 32'h0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                h = (h * 32'd31) + 32'(b[r][c]);
        return h;
    endfunction

    task automatic fill_blk(input int unsigned idx, input int unsigned ch,
                            output logic signed [10:0] b [0:7][0:7]);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = 11'(idx * 37 + ch * 211 + 32'(r) * 8 + 32'(c) * 3 + 5);
    endtask

    typedef struct {
        int unsigned idx;
        logic [1:0]  ch;
    } sb_t;

    sb_t                sb[$];
    sb_t                e;
    int unsigned        n_hs;
    logic               hs_seen, hs_prev, tsel_prev, hs_m, pop_m;
    logic [1:0]         exp_chan;
    logic [2:0]         exp_rdy, vld;
    int                 fc_m, infl;
    logic               err_m;
    logic [15:0]        mcu_m;
    logic signed [10:0] eb [0:7][0:7];

    task automatic drive_blocks();
        fill_blk(n_hs, 0, y_z);
        fill_blk(n_hs, 1, cb_z);
        fill_blk(n_hs, 2, cr_z);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (hs_seen) begin
            n_hs++;
            hs_seen = 1'b0;
            drive_blocks();
        end
    endtask

    task automatic set_valid(input logic [2:0] v);
        {cr_valid, cb_valid, y_valid} = v;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_ready"},    32'({cr_ready, cb_ready, y_ready}), 32'b001);
        check({tag, "_q_enable"}, 32'(q_enable), 0);
        check({tag, "_q_tsel"},   32'(q_table_sel), 0);
        check({tag, "_q_z"},      blk_hash(q_z), 0);
        check({tag, "_out_valid"},32'(out_valid), 0);
        check({tag, "_out_chan"}, 32'(out_chan), 0);
        check({tag, "_out_blk"},  blk_hash(out_blk), 0);
        check({tag, "_mcu_done"}, 32'(mcu_done), 0);
        check({tag, "_mcu_count"},32'(mcu_count), 0);
        check({tag, "_err"},      32'(err), 0);
    endtask

    // Per-cycle model: ready from credit and MCU order, issue one cycle after handshake,
    // results captured when the model quantizer fires, FIFO head compared on pop.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            fc_m = 0; exp_chan = 2'd0; err_m = 1'b0; mcu_m = 16'd0;
            hs_prev = 1'b0; tsel_prev = 1'b0; hs_seen = 1'b0;
        end else begin
            infl    = sb.size() - fc_m;
            exp_rdy = (sb.size() < 4) ? (3'b001 << exp_chan) : 3'b000;
            check("ready", 32'({cr_ready, cb_ready, y_ready}), 32'(exp_rdy));
            check("q_enable", 32'(q_enable), 32'(hs_prev));
            if (hs_prev) check("q_table_sel", 32'(q_table_sel), 32'(tsel_prev));
            check("out_valid", 32'(out_valid), 32'(fc_m != 0));
            check("err", 32'(err), 32'(err_m));
            check("mcu_count", 32'(mcu_count), 32'(mcu_m));
            vld   = {cr_valid, cb_valid, y_valid};
            hs_m  = (exp_rdy & vld) != 3'b000;
            pop_m = (fc_m != 0) && out_ready;
            if (pop_m) begin
                e = sb.pop_front();
                fill_blk(e.idx, 32'(e.ch), eb);
                check("out_chan", 32'(out_chan), 32'(e.ch));
                check("out_blk", blk_hash(out_blk), blk_hash(eb));
                check("mcu_done", 32'(mcu_done), 32'(e.ch == 2'd2));
                if (e.ch == 2'd2) mcu_m = mcu_m + 16'd1;
                fc_m--;
            end else begin
                check("mcu_done_idle", 32'(mcu_done), 0);
            end
            if (pipe_v[3] | spur) begin
                if (infl > 0) fc_m++;
                else          err_m = 1'b1;
            end
            if (hs_m) begin
                sb.push_back('{idx: n_hs, ch: exp_chan});
                hs_seen   = 1'b1;
                tsel_prev = (exp_chan != 2'd0);
                exp_chan  = (exp_chan == 2'd2) ? 2'd0 : exp_chan + 2'd1;
            end
            hs_prev = hs_m;
        end
    end

    initial begin
        rst = 1'b1; spur = 1'b0; out_ready = 1'b1; n_hs = 0; hs_seen = 1'b0;
        set_valid(3'b000);
        drive_blocks();
        tick(); tick();
        reset_checks("reset");
        rst = 1'b0;

        // Single MCU with all valids high.
        set_valid(3'b111); repeat (3) tick();
        set_valid(3'b000); repeat (10) tick();
        check("single_mcu_count", 32'(mcu_count), 1);

        // Out-of-order valids must not be acknowledged.
        set_valid(3'b110); repeat (10) tick();
        set_valid(3'b111); repeat (3) tick();
        set_valid(3'b000); repeat (10) tick();

        // Backpressure, then a one-cycle pop while full.
        out_ready = 1'b0; set_valid(3'b111); repeat (15) tick();
        check("bp_ready_low", 32'({cr_ready, cb_ready, y_ready}), 0);
        check("bp_full", 32'(out_valid), 1);
        out_ready = 1'b1; tick();
        out_ready = 1'b0; repeat (8) tick();
        out_ready = 1'b1; set_valid(3'b000); repeat (15) tick();

        // Spurious result while idle.
        spur = 1'b1; tick();
        spur = 1'b0; repeat (5) tick();
        check("err_sticky", 32'(err), 1);
        check("spur_no_out", 32'(out_valid), 0);

        // Reset with two in flight and two buffered.
        out_ready = 1'b0; set_valid(3'b111); repeat (4) tick();
        set_valid(3'b000); repeat (3) tick();
        rst = 1'b1; tick();
        reset_checks("midreset");
        rst = 1'b0;
        out_ready = 1'b1; set_valid(3'b111); repeat (3) tick();
        set_valid(3'b000); repeat (10) tick();
        check("restart_mcu_count", 32'(mcu_count), 1);

        for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
        check("drain", 32'(sb.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
